// File: rtl/mult_seq_ctrl_if.sv
// Handshake and datapath-strobe bundle between the multiplier controller and its
// issuing unit / shift-and-add datapath.
interface mult_seq_ctrl_if #(
   parameter int CW = 5
);
   logic          Start;
   logic          M;
   logic          Load;
   logic          Ad;
   logic          Sh;
   logic          Busy;
   logic          Done;
   logic [CW-1:0] Iter;

   modport master (
      output Start, M,
      input  Load, Ad, Sh, Busy, Done, Iter
   );

   modport slave (
      input  Start, M,
      output Load, Ad, Sh, Busy, Done, Iter
   );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Control FSM for a shift-and-add multiplier: Load, then WIDTH shifts with an add before each set LSB.
// Done follows Start sampling by 1+WIDTH+popcount edges and is held until Start drops (4-phase).
module mult_seq_ctrl #(
   parameter int WIDTH = 16,
   parameter int CW    = 5
) (
   input logic          Clk,
   input logic          Rst_n,
   mult_seq_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      ADDED = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t        state;
   logic [CW-1:0] iter;
   logic          load_q;
   logic          busy_q;
   logic          done_q;

   // Load/Busy/Done are registered from the next state; Iter only moves on a shift.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state  <= IDLE;
         iter   <= '0;
         load_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.Start) begin
                  state  <= LOAD;
                  load_q <= 1'b1;
                  busy_q <= 1'b1;
               end
            end
            LOAD: begin
               state  <= RUN;
               load_q <= 1'b0;
               iter   <= '0;
            end
            RUN: begin
               if (bus.M) begin
                  state <= ADDED;
               end else begin
                  iter <= iter + CW'(1);
                  if (iter == LAST) begin
                     state  <= DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end
               end
            end
            ADDED: begin
               iter <= iter + CW'(1);
               if (iter == LAST) begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else begin
                  state <= RUN;
               end
            end
            DONE: begin
               if (!bus.Start) begin
                  state  <= IDLE;
                  done_q <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               load_q <= 1'b0;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   // Ad/Sh follow M combinationally in RUN so the add decision costs no extra cycle.
   assign bus.Ad   = (state == RUN) && bus.M;
   assign bus.Sh   = ((state == RUN) && !bus.M) || (state == ADDED);
   assign bus.Load = load_q;
   assign bus.Busy = busy_q;
   assign bus.Done = done_q;
   assign bus.Iter = iter;

endmodule
